// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_fetch_unit                                                |
// | Description : Instruction-fetch stage: issues pc on the SRAM-like          |
// |               instruction bus and delivers the fetched word to decode      |
// |               through the IF/ID register.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_fetch_unit #(
    parameter int          EXC_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             i_en,
    input  logic [EXC_W-1:0] excp_in,
    input  logic             stall,
    input  logic             flush,
    output logic             ibus_req,
    output logic [31:0]      ibus_addr,
    input  logic             ibus_addr_ok,
    input  logic             ibus_data_ok,
    input  logic [31:0]      ibus_rdata,
    output logic             if_stall_req,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic [EXC_W-1:0] id_excp,
    output logic             id_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_hold_pc;
    logic [31:0]      r_hold_inst;

    logic             w_excp_pend;
    logic             w_accept;
    logic             w_capture;
    logic             w_load;
    logic [31:0]      w_load_pc;
    logic [31:0]      w_load_inst;
    logic [EXC_W-1:0] w_load_excp;

    assign w_excp_pend = (excp_in != '0);
    assign ibus_addr   = pc;
    assign w_accept    = ibus_req && ibus_addr_ok;

    // Next state, bus handshake and IF/ID load selection. if_stall_req only
    // depends on state, control inputs and data_ok, never on ibus_rdata.
    always_comb begin
        w_state_nxt  = r_state;
        ibus_req     = 1'b0;
        if_stall_req = 1'b0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_load_pc    = r_fetch_pc;
        w_load_inst  = NOP_INST;
        w_load_excp  = '0;

        case (r_state)
            S_IDLE: begin
                if (i_en && !flush) begin
                    if (w_excp_pend) begin
                        w_load      = 1'b1;
                        w_load_pc   = pc;
                        w_load_excp = excp_in;
                    end else begin
                        ibus_req     = 1'b1;
                        if_stall_req = 1'b1;
                        if (ibus_addr_ok) begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (ibus_data_ok) begin
                    w_state_nxt = S_IDLE;
                    if (!flush) begin
                        if (stall) begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_load      = 1'b1;
                            w_load_inst = ibus_rdata;
                        end
                    end
                end else begin
                    if_stall_req = 1'b1;
                    if (flush) begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end

            S_HOLD: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_load_pc   = r_hold_pc;
                    w_load_inst = r_hold_inst;
                    w_state_nxt = S_IDLE;
                end
            end

            S_DISCARD: begin
                // The flushed request is still in flight; its data must be
                // absorbed before a new request may be issued.
                if_stall_req = 1'b1;
                if (ibus_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= 32'h0;
            r_hold_pc   <= 32'h0;
            r_hold_inst <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_fetch_pc <= pc;
            end
            if (w_capture) begin
                r_hold_pc   <= r_fetch_pc;
                r_hold_inst <= ibus_rdata;
            end
        end
    end

    // IF/ID register: flush > stall > load > bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc    <= 32'h0;
            id_inst  <= NOP_INST;
            id_excp  <= '0;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_inst  <= NOP_INST;
            id_excp  <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            if (w_load) begin
                id_pc    <= w_load_pc;
                id_inst  <= w_load_inst;
                id_excp  <= w_load_excp;
                id_valid <= 1'b1;
            end else begin
                id_inst  <= NOP_INST;
                id_excp  <= '0;
                id_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_fetch_unit                                             |
// | Description : Self-checking bench for if_fetch_unit.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_if_fetch_unit;

    localparam int          EXC_W = 16;
    localparam logic [31:0] C_NOP = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc;
    logic             i_en;
    logic [EXC_W-1:0] excp_in;
    logic             stall;
    logic             flush;
    logic             ibus_req;
    logic [31:0]      ibus_addr;
    logic             ibus_addr_ok;
    logic             ibus_data_ok;
    logic [31:0]      ibus_rdata;
    logic             if_stall_req;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic [EXC_W-1:0] id_excp;
    logic             id_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(.EXC_W(EXC_W), .NOP_INST(C_NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .i_en         (i_en),
        .excp_in      (excp_in),
        .stall        (stall),
        .flush        (flush),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_data_ok (ibus_data_ok),
        .ibus_rdata   (ibus_rdata),
        .if_stall_req (if_stall_req),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_excp      (id_excp),
        .id_valid     (id_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory content seen by the bus slave.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
    endfunction

    typedef struct {
        logic             en;
        logic [31:0]      pc;
        logic [EXC_W-1:0] excp;
        logic             st;
        logic             fl;
        logic             ao;
        logic             dok;
        logic [31:0]      rdata;
        logic             e_req;
        logic             e_sreq;
        logic             e_valid;
        logic [31:0]      e_inst;
        logic [31:0]      e_pc;
        logic [EXC_W-1:0] e_excp;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [31:0] p, input logic [EXC_W-1:0] ex,
                                input logic st, input logic fl, input logic ao, input logic dok,
                                input logic [31:0] rd, input logic e_req, input logic e_sreq,
                                input logic e_valid, input logic [31:0] e_inst,
                                input logic [31:0] e_pc, input logic [EXC_W-1:0] e_excp);
        vec_t v;
        v.en = en; v.pc = p; v.excp = ex; v.st = st; v.fl = fl; v.ao = ao; v.dok = dok;
        v.rdata = rd; v.e_req = e_req; v.e_sreq = e_sreq; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_excp = e_excp;
        return v;
    endfunction

    task automatic drive(input logic en, input logic [31:0] p, input logic [EXC_W-1:0] ex,
                         input logic st, input logic fl, input logic ao, input logic dok,
                         input logic [31:0] rd);
        @(negedge clk);
        i_en = en; pc = p; excp_in = ex; stall = st; flush = fl;
        ibus_addr_ok = ao; ibus_data_ok = dok; ibus_rdata = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] p, input logic [EXC_W-1:0] ex);
        check({tag, ".valid"}, id_valid, v);
        check({tag, ".inst"}, id_inst, inst);
        check({tag, ".pc"}, id_pc, p);
        check({tag, ".excp"}, id_excp, ex);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        i_en = 1'b0; pc = 32'h0; excp_in = '0; stall = 1'b0; flush = 1'b0;
        ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[10];

    // Reference model of the fetch stage, kept as transaction bookkeeping.
    bit               m_out, m_dead, m_buf;
    logic [31:0]      m_out_pc, m_buf_pc, m_buf_inst;
    logic             m_valid;
    logic [31:0]      m_pc, m_inst;
    logic [EXC_W-1:0] m_excp;
    bit               s_pend;
    int               s_cnt;
    logic [31:0]      s_addr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 32'hBFC0_0000, 16'h0, 0, 0, 0, 0, 32'h0,         1, 1, 0, C_NOP,        32'h0,         16'h0);
        vecs[1] = mk(1, 32'hBFC0_0000, 16'h0, 0, 0, 1, 0, 32'h0,         1, 1, 0, C_NOP,        32'h0,         16'h0);
        vecs[2] = mk(1, 32'hBFC0_0000, 16'h0, 0, 0, 0, 0, 32'h0,         0, 1, 0, C_NOP,        32'h0,         16'h0);
        vecs[3] = mk(1, 32'hBFC0_0000, 16'h0, 0, 0, 0, 1, 32'h2408_0001, 0, 0, 1, 32'h2408_0001, 32'hBFC0_0000, 16'h0);
        vecs[4] = mk(0, 32'hBFC0_0004, 16'h0, 0, 0, 0, 0, 32'h0,         0, 0, 0, C_NOP,        32'hBFC0_0000, 16'h0);
        vecs[5] = mk(1, 32'h0000_0002, 16'h1, 0, 0, 0, 0, 32'h0,         0, 0, 1, C_NOP,        32'h0000_0002, 16'h1);
        vecs[6] = mk(0, 32'h0000_0010, 16'h0, 1, 1, 0, 0, 32'h0,         0, 0, 0, C_NOP,        32'h0000_0002, 16'h0);
        vecs[7] = mk(1, 32'h0000_0004, 16'h2, 1, 0, 0, 0, 32'h0,         0, 0, 0, C_NOP,        32'h0000_0002, 16'h0);
        vecs[8] = mk(1, 32'h0000_0004, 16'h2, 0, 0, 0, 0, 32'h0,         0, 0, 1, C_NOP,        32'h0000_0004, 16'h2);
        vecs[9] = mk(0, 32'h0000_0008, 16'h0, 0, 0, 0, 0, 32'h0,         0, 0, 0, C_NOP,        32'h0000_0004, 16'h0);

        do_reset();
        #1;
        check_id("reset", 1'b0, C_NOP, 32'h0, '0);
        check("reset.req", ibus_req, 1'b0);
        check("reset.sreq", if_stall_req, 1'b0);

        // Basic fetch, exception bypass, flush-vs-stall on the IF/ID register.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].en, vecs[i].pc, vecs[i].excp, vecs[i].st, vecs[i].fl,
                  vecs[i].ao, vecs[i].dok, vecs[i].rdata);
            check($sformatf("vec%0d.req", i), ibus_req, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("vec%0d.addr", i), ibus_addr, vecs[i].pc);
            check($sformatf("vec%0d.sreq", i), if_stall_req, vecs[i].e_sreq);
            tick();
            check_id($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_excp);
        end

        // Flush while waiting: stale word is swallowed, flush target fetched next.
        drive(1, 32'h0040_0000, '0, 0, 0, 1, 0, 32'h0);
        check("disc.req0", ibus_req, 1'b1);
        tick();
        drive(1, 32'h0040_0000, '0, 0, 1, 0, 0, 32'h0);
        check("disc.req1", ibus_req, 1'b0);
        tick();
        check("disc.valid1", id_valid, 1'b0);
        drive(1, 32'h8000_0180, '0, 0, 0, 0, 0, 32'h0);
        check("disc.req2", ibus_req, 1'b0);
        check("disc.sreq2", if_stall_req, 1'b1);
        tick();
        drive(1, 32'h8000_0180, '0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("disc.req3", ibus_req, 1'b0);
        check("disc.sreq3", if_stall_req, 1'b1);
        tick();
        check("disc.inst3", id_inst, C_NOP);
        check("disc.valid3", id_valid, 1'b0);
        drive(1, 32'h8000_0180, '0, 0, 0, 1, 0, 32'h0);
        check("disc.req4", ibus_req, 1'b1);
        check("disc.addr4", ibus_addr, 32'h8000_0180);
        tick();
        drive(1, 32'h8000_0180, '0, 0, 0, 0, 1, 32'h3C1A_8000);
        check("disc.sreq5", if_stall_req, 1'b0);
        tick();
        check_id("disc5", 1'b1, 32'h3C1A_8000, 32'h8000_0180, '0);

        // Data returns under stall: parked, then delivered exactly once.
        drive(1, 32'h0000_1000, '0, 1, 0, 1, 0, 32'h0);
        check("hold.req0", ibus_req, 1'b1);
        tick();
        check_id("hold0", 1'b1, 32'h3C1A_8000, 32'h8000_0180, '0);
        drive(1, 32'h0000_1000, '0, 1, 0, 0, 1, 32'hA5A5_0001);
        check("hold.sreq1", if_stall_req, 1'b0);
        tick();
        check_id("hold1", 1'b1, 32'h3C1A_8000, 32'h8000_0180, '0);
        for (int i = 2; i < 4; i++) begin
            drive(1, 32'h0000_1000, '0, 1, 0, 0, 0, 32'h0);
            check($sformatf("hold.req%0d", i), ibus_req, 1'b0);
            check($sformatf("hold.sreq%0d", i), if_stall_req, 1'b0);
            tick();
            check_id($sformatf("hold%0d", i), 1'b1, 32'h3C1A_8000, 32'h8000_0180, '0);
        end
        drive(1, 32'h0000_1000, '0, 0, 0, 0, 0, 32'h0);
        tick();
        check_id("hold4", 1'b1, 32'hA5A5_0001, 32'h0000_1000, '0);
        drive(0, 32'h0000_1004, '0, 0, 0, 0, 0, 32'h0);
        tick();
        check("hold.once", id_valid, 1'b0);

        // Request not accepted for several cycles, flushed in cycle 3.
        for (int c = 0; c < 6; c++) begin
            logic [31:0] p;
            logic        fl;
            p  = (c >= 4) ? 32'h8000_0180 : 32'h0000_2000;
            fl = (c == 3);
            drive(1, p, '0, 0, fl, 0, 0, 32'h0);
            check($sformatf("aok.req%0d", c), ibus_req, !fl);
            if (!fl) check($sformatf("aok.addr%0d", c), ibus_addr, p);
            check($sformatf("aok.sreq%0d", c), if_stall_req, !fl);
            tick();
        end
        drive(0, 32'h0, '0, 0, 0, 0, 0, 32'h0);
        tick();

        // Asynchronous reset in the middle of an outstanding fetch.
        drive(1, 32'h0000_3000, '0, 0, 0, 1, 0, 32'h0);
        tick();
        drive(1, 32'h0000_3000, '0, 0, 0, 0, 1, 32'h1111_2222);
        tick();
        check_id("rstw0", 1'b1, 32'h1111_2222, 32'h0000_3000, '0);
        drive(1, 32'h0000_3004, '0, 1, 0, 1, 0, 32'h0);
        tick();
        @(negedge clk);
        i_en = 1'b0; stall = 1'b0; ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_id("rstw1", 1'b0, C_NOP, 32'h0, '0);
        check("rstw.req", ibus_req, 1'b0);
        check("rstw.sreq", if_stall_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 32'h0000_3004, '0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("rstw.late_sreq", if_stall_req, 1'b0);
        check("rstw.late_req", ibus_req, 1'b0);
        tick();
        check("rstw.late_valid", id_valid, 1'b0);
        check("rstw.late_inst", id_inst, C_NOP);
        drive(1, 32'h0000_4000, '0, 0, 0, 0, 0, 32'h0);
        check("rstw.idle_req", ibus_req, 1'b1);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        m_out = 0; m_dead = 0; m_buf = 0; m_out_pc = 0; m_buf_pc = 0; m_buf_inst = 0;
        m_valid = 0; m_pc = 0; m_inst = C_NOP; m_excp = '0;
        s_pend = 0; s_cnt = 0; s_addr = 0;
        begin
            bit               adv;
            logic             en, st, fl, ao, dok, e_req, e_sreq, ld;
            logic [31:0]      p, rd, l_pc, l_inst;
            logic [EXC_W-1:0] ex, l_excp;
            adv = 1; en = 0; p = 0; ex = '0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                check("rnd.valid", id_valid, m_valid);
                check("rnd.inst", id_inst, m_inst);
                check("rnd.pc", id_pc, m_pc);
                check("rnd.excp", id_excp, m_excp);
                if (id_valid && id_excp == '0) check("rnd.memword", id_inst, mem(id_pc));

                if (adv) begin
                    en = ($urandom_range(0, 7) != 0);
                    p  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    p[31:30] = 2'($urandom_range(0, 3));
                    ex = ($urandom_range(0, 9) == 0) ? EXC_W'(1 << $urandom_range(0, 2)) : '0;
                end
                st = ($urandom_range(0, 4) == 0);
                fl = ($urandom_range(0, 19) == 0);
                e_req = !m_out && !m_buf && en && !fl && (ex == '0);
                ao  = e_req && ($urandom_range(0, 2) == 0);
                dok = 1'b0;
                rd  = $urandom;
                if (s_pend) begin
                    if (s_cnt == 0) begin
                        dok = 1'b1;
                        rd  = mem(s_addr);
                        s_pend = 0;
                    end else begin
                        s_cnt--;
                    end
                end
                if (ao) begin
                    s_pend = 1;
                    s_cnt  = $urandom_range(0, 3);
                    s_addr = p;
                end
                i_en = en; pc = p; excp_in = ex; stall = st; flush = fl;
                ibus_addr_ok = ao; ibus_data_ok = dok; ibus_rdata = rd;
                #1;

                if (m_out) e_sreq = m_dead ? 1'b1 : !dok;
                else if (m_buf) e_sreq = 1'b0;
                else e_sreq = e_req;
                check("rnd.req", ibus_req, e_req);
                if (e_req) check("rnd.addr", ibus_addr, p);
                if (!(m_out && !m_dead && !dok && fl)) check("rnd.sreq", if_stall_req, e_sreq);

                ld = 0; l_pc = 0; l_inst = C_NOP; l_excp = '0;
                if (m_buf) begin
                    ld = 1; l_pc = m_buf_pc; l_inst = m_buf_inst;
                end else if (m_out && !m_dead && dok) begin
                    ld = 1; l_pc = m_out_pc; l_inst = rd;
                end else if (!m_out && en && ex != '0) begin
                    ld = 1; l_pc = p; l_excp = ex;
                end
                if (fl) begin
                    m_valid = 0; m_inst = C_NOP; m_excp = '0;
                end else if (!st) begin
                    if (ld) begin
                        m_valid = 1; m_pc = l_pc; m_inst = l_inst; m_excp = l_excp;
                    end else begin
                        m_valid = 0; m_inst = C_NOP; m_excp = '0;
                    end
                end
                if (m_buf && (fl || !st)) m_buf = 0;
                if (m_out && dok) begin
                    if (!m_dead && !fl && st) begin
                        m_buf = 1; m_buf_pc = m_out_pc; m_buf_inst = rd;
                    end
                    m_out = 0; m_dead = 0;
                end else if (m_out && fl) begin
                    m_dead = 1;
                end
                if (ao) begin
                    m_out = 1; m_out_pc = p;
                end
                adv = fl || (!e_sreq && !st);
                @(posedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
